key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Conditions up to N_KEYS raw push-button inputs for the control FSMs.
- Runs on the crystal clock. Uses the debounce tick level from the frequency divider (its clk_debounce output) as a sample enable, so it adds no new clock domain.
- Per key: synchronizes, debounces by N-of-N agreement, and produces a stable level plus single-cycle press, release and auto-repeat pulses.

Parameters:
- N_KEYS, 4: number of independent keys.
- DEPTH, 4: consecutive agreeing samples required to change level; legal range 2..16.
- HOLD_TICKS, 250: sample ticks a key stays held before the first repeat pulse; legal range 1..2^CNT_W-1.
- REPEAT_TICKS, 50: sample ticks between subsequent repeat pulses; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of each per-key tick counter.

Ports:
- clk  input  1  crystal clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- deb_clk_in  input  1  debounce tick level (clk_debounce from the divider); synchronous to clk.
- pb_in  input  N_KEYS  raw buttons, active-high (1 = pressed); asynchronous.
- pb_level  output  N_KEYS  debounced key state.
- pb_press  output  N_KEYS  1-clk pulse on debounced 0->1.
- pb_release  output  N_KEYS  1-clk pulse on debounced 1->0.
- pb_rpt  output  N_KEYS  1-clk auto-repeat pulse while held.
- pb_act  output  N_KEYS  pb_press | pb_rpt, for increment/step logic.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; shift registers, synchronizers and counters 0; every key FSM in IDLE; deb_q = 1.
- Synchronizer: two flops per key, pb_in -> pb_sync. Latency is 2 clk.
- Tick generation: deb_q <= deb_clk_in; tick = deb_clk_in & ~deb_q (combinational, 1 clk wide per rising edge of deb_clk_in).
  - deb_q resets to 1, so no spurious tick occurs if deb_clk_in is already high at reset release.
- On a tick cycle, per key i:
  - sh_next = {sh[DEPTH-2:0], pb_sync[i]}; sh <= sh_next.
  - lvl_next = 1 if sh_next is all ones, 0 if all zeros, otherwise pb_level[i]; pb_level[i] <= lvl_next.
- Off-tick cycles: sh, pb_level and counters hold; pb_press, pb_release and pb_rpt are 0.
- Pulses are registered and coincide with the first cycle of the new pb_level value:
  - pb_press <= tick & ~pb_level & lvl_next.
  - pb_release <= tick & pb_level & ~lvl_next.
- Per-key FSM (all transitions evaluated only on tick), with counter cnt:
  - IDLE: if lvl_next=1, go to HELD and set cnt=0.
  - HELD: if lvl_next=0, go to IDLE and set cnt=0. Otherwise cnt+1; if cnt+1 == HOLD_TICKS, go to REPEAT, set cnt=0 and pulse pb_rpt.
  - REPEAT: if lvl_next=0, go to IDLE and set cnt=0. Otherwise cnt+1; if cnt+1 == REPEAT_TICKS, set cnt=0 and pulse pb_rpt.
- Release takes priority: when release and count-reached happen on the same tick, pb_rpt is not asserted.
- pb_press and pb_rpt are never both 1 in the same cycle.
- Counters never wrap, since they reload before reaching 2^CNT_W-1.
- Keys are fully independent; simultaneous events on different keys each produce their own pulses in the same cycle.
- Reset asserted mid-hold: all outputs clear immediately. After release, a still-held key needs DEPTH fresh ticks to give a new pb_press, and HOLD restarts from 0.
- Max press-detect latency: 2 clk + DEPTH tick periods + 1 clk.

Test Plan:
- Reset then idle (pb_in=0, deb_clk_in toggling every 16 clk) -> all outputs stay 0. deb_clk_in=1 at reset release -> no tick and no sh change until the next rising edge.
- DEPTH=4, key0 held steady high -> pb_level[0] rises 1 clk after the 4th tick; pb_press[0]=1 for exactly 1 clk; pb_act[0] matches. Release -> pb_release[0] 1 clk after the 4th low tick.
- Bounce: key1 sampled 1,0,1,1,0,1,1,1 on successive ticks -> pb_level[1] rises only after the last of 4 consecutive 1s; exactly one pb_press; no pb_release.
- Auto-repeat with HOLD_TICKS=8, REPEAT_TICKS=2: hold key2 -> pb_press at tick 4, pb_rpt at ticks 12, 14, 16, ...; release so pb_level falls on the tick a repeat was due -> no pb_rpt on that tick, pb_release=1.
- Keys 0 and 3 pressed on the same sample -> pb_press=4'b1001 in one cycle; key 3 released early -> key 0 repeat timing unaffected.
- rst_n pulsed low while key2 in REPEAT -> outputs 0 asynchronously. Key still held after reset -> new pb_press after 4 ticks; first pb_rpt HOLD_TICKS later.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop sync, N-of-N debounce on divider ticks,
// debounced level plus single-cycle press/release/auto-repeat pulses per key.
module key_conditioner #(
  parameter int N_KEYS       = 4,
  parameter int DEPTH        = 4,
  parameter int HOLD_TICKS   = 250,
  parameter int REPEAT_TICKS = 50,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              deb_clk_in,
  input  logic [N_KEYS-1:0] pb_in,
  output logic [N_KEYS-1:0] pb_level,
  output logic [N_KEYS-1:0] pb_press,
  output logic [N_KEYS-1:0] pb_release,
  output logic [N_KEYS-1:0] pb_rpt,
  output logic [N_KEYS-1:0] pb_act
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] RPT_C  = CNT_W'(REPEAT_TICKS);

  logic              r_deb_q;
  logic              w_tick;
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [DEPTH-1:0]  r_sh        [N_KEYS];
  logic [DEPTH-1:0]  w_sh_next   [N_KEYS];
  logic [N_KEYS-1:0] w_lvl_next;
  logic [N_KEYS-1:0] w_rpt_next;
  key_state_t        r_state     [N_KEYS];
  key_state_t        w_state_next[N_KEYS];
  logic [CNT_W-1:0]  r_cnt       [N_KEYS];
  logic [CNT_W-1:0]  w_cnt_next  [N_KEYS];
  logic [CNT_W-1:0]  w_cnt_inc   [N_KEYS];

  // Rising edge of the divider level is the sample enable; deb_q resets high
  // so a level already high at reset release does not count as an edge.
  assign w_tick = deb_clk_in & ~r_deb_q;
  assign pb_act = pb_press | pb_rpt;

  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      w_sh_next[i]    = {r_sh[i][DEPTH-2:0], r_sync2[i]};
      w_lvl_next[i]   = (&w_sh_next[i])  ? 1'b1 :
                        (~|w_sh_next[i]) ? 1'b0 : pb_level[i];
      w_cnt_inc[i]    = r_cnt[i] + CNT_W'(1);
      w_state_next[i] = r_state[i];
      w_cnt_next[i]   = r_cnt[i];
      w_rpt_next[i]   = 1'b0;
      if (w_tick) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_lvl_next[i]) begin
              w_state_next[i] = ST_HELD;
              w_cnt_next[i]   = '0;
            end
          end
          ST_HELD: begin
            if (!w_lvl_next[i]) begin
              w_state_next[i] = ST_IDLE;
              w_cnt_next[i]   = '0;
            end else if (w_cnt_inc[i] == HOLD_C) begin
              w_state_next[i] = ST_REPEAT;
              w_cnt_next[i]   = '0;
              w_rpt_next[i]   = 1'b1;
            end else begin
              w_cnt_next[i]   = w_cnt_inc[i];
            end
          end
          ST_REPEAT: begin
            // Release wins over a repeat that falls due on the same tick.
            if (!w_lvl_next[i]) begin
              w_state_next[i] = ST_IDLE;
              w_cnt_next[i]   = '0;
            end else if (w_cnt_inc[i] == RPT_C) begin
              w_cnt_next[i]   = '0;
              w_rpt_next[i]   = 1'b1;
            end else begin
              w_cnt_next[i]   = w_cnt_inc[i];
            end
          end
          default: begin
            w_state_next[i] = ST_IDLE;
            w_cnt_next[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_q    <= 1'b1;
      r_sync1    <= '0;
      r_sync2    <= '0;
      pb_level   <= '0;
      pb_press   <= '0;
      pb_release <= '0;
      pb_rpt     <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_sh[i]    <= '0;
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_deb_q    <= deb_clk_in;
      r_sync1    <= pb_in;
      r_sync2    <= r_sync1;
      pb_press   <= {N_KEYS{w_tick}} & ~pb_level & w_lvl_next;
      pb_release <= {N_KEYS{w_tick}} & pb_level & ~w_lvl_next;
      pb_rpt     <= w_rpt_next;
      if (w_tick) begin
        pb_level <= w_lvl_next;
        for (int i = 0; i < N_KEYS; i++) begin
          r_sh[i] <= w_sh_next[i];
        end
      end
      for (int i = 0; i < N_KEYS; i++) begin
        r_state[i] <= w_state_next[i];
        r_cnt[i]   <= w_cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEPTH=4, HOLD=8, REPEAT=2): expected
// pulse events are queued per tick number and compared every clock.
module tb_key_conditioner;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         deb_clk_in;
  logic [N-1:0] pb_in;
  logic [N-1:0] pb_level, pb_press, pb_release, pb_rpt, pb_act;

  typedef struct packed {
    int           tick;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rpt;
    logic [N-1:0] lvl;
  } ev_t;

  ev_t          exp_q[$];
  logic [N-1:0] exp_lvl;
  int           tick_no;
  int           passed;
  int           total;

  key_conditioner #(
    .N_KEYS(N), .DEPTH(4), .HOLD_TICKS(8), .REPEAT_TICKS(2), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .deb_clk_in (deb_clk_in),
    .pb_in      (pb_in),
    .pb_level   (pb_level),
    .pb_press   (pb_press),
    .pb_release (pb_release),
    .pb_rpt     (pb_rpt),
    .pb_act     (pb_act)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog tick=%0d observed=timeout expected=finish", tick_no);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s tick=%0d observed=%h expected=%h", tag, tick_no, obs, exp);
  endtask

  function automatic logic [31:0] outs();
    return {12'd0, pb_press, pb_release, pb_rpt, pb_act, pb_level};
  endfunction

  task automatic expect_ev(input int t, input logic [N-1:0] p, input logic [N-1:0] r,
                           input logic [N-1:0] rp, input logic [N-1:0] l);
    ev_t e;
    e.tick = t; e.press = p; e.rel = r; e.rpt = rp; e.lvl = l;
    exp_q.push_back(e);
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_step();
    step();
    check("quiet", outs(), {12'd0, 16'd0, exp_lvl});
  endtask

  task automatic do_tick();
    ev_t          e;
    logic [N-1:0] ep, er, erp;
    deb_clk_in = 1'b0;
    repeat (8) quiet_step();
    deb_clk_in = 1'b1;
    tick_no++;
    step();
    ep = '0; er = '0; erp = '0;
    if (exp_q.size() > 0 && exp_q[0].tick == tick_no) begin
      e       = exp_q.pop_front();
      ep      = e.press;
      er      = e.rel;
      erp     = e.rpt;
      exp_lvl = e.lvl;
    end
    check("tick", outs(), {12'd0, ep, er, erp, ep | erp, exp_lvl});
    repeat (7) quiet_step();
  endtask

  logic [12:0] bounce_pat;

  initial begin
    passed = 0; total = 0; tick_no = 0; exp_lvl = '0;
    rst_n = 1'b0; deb_clk_in = 1'b1; pb_in = 4'b0001;
    repeat (3) begin
      step();
      check("reset_outputs", outs(), 32'd0);
    end
    // release reset with deb_clk_in already high: no tick may be counted
    rst_n = 1'b1;
    repeat (4) quiet_step();

    // key0 held from reset release, then released; keys 1..3 idle
    expect_ev(4, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    expect_ev(8, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    repeat (4) do_tick();
    pb_in[0] = 1'b0;
    repeat (6) do_tick();
    check("drain_a", exp_q.size(), 0);

    // key1 bounce 1,0,1,1,0,1,1,1 then a 4th steady one, then released
    bounce_pat = 13'b1011011110000;
    expect_ev(19, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    expect_ev(23, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    for (int k = 0; k < 13; k++) begin
      pb_in[1] = bounce_pat[12-k];
      do_tick();
    end
    check("drain_b", exp_q.size(), 0);

    // key2 auto-repeat; level falls on a tick where a repeat was due
    expect_ev(27, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    expect_ev(35, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    expect_ev(37, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    expect_ev(39, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    expect_ev(41, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    expect_ev(43, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    pb_in[2] = 1'b1;
    for (int k = 24; k <= 43; k++) begin
      if (k == 40) pb_in[2] = 1'b0;
      do_tick();
    end
    check("drain_c", exp_q.size(), 0);

    // keys 0 and 3 together; key3 released early, key0 repeats undisturbed
    expect_ev(47, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    expect_ev(52, 4'b0000, 4'b1000, 4'b0000, 4'b0001);
    expect_ev(55, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    expect_ev(57, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    expect_ev(59, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    expect_ev(61, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    expect_ev(63, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    pb_in = 4'b1001;
    for (int k = 44; k <= 63; k++) begin
      if (k == 49) pb_in[3] = 1'b0;
      if (k == 60) pb_in[0] = 1'b0;
      do_tick();
    end
    check("drain_d", exp_q.size(), 0);

    // key2 into REPEAT, then an asynchronous reset while it is still held
    expect_ev(67, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    expect_ev(75, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    expect_ev(77, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    pb_in[2] = 1'b1;
    for (int k = 64; k <= 77; k++) do_tick();
    check("drain_e1", exp_q.size(), 0);
    check("level_before_reset", {28'd0, pb_level}, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 32'd0);
    exp_lvl = '0;
    repeat (3) begin
      step();
      check("reset_hold", outs(), 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) quiet_step();
    expect_ev(81, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    expect_ev(89, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    expect_ev(91, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    expect_ev(93, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    for (int k = 78; k <= 94; k++) begin
      if (k == 90) pb_in[2] = 1'b0;
      do_tick();
    end
    check("drain_e2", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
